// File: rtl/udma_lin_tx_arbiter.sv
// Round-robin arbiter for N_CH linear TX channels sharing one L2 read port,
// with an in-order ID FIFO to route read responses. Define UDMA_ARB_PRIO_EN to enable priority-masked arbitration.
module udma_lin_tx_arbiter #(
   parameter int unsigned N_CH   = 10,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic [N_CH-1:0]          req_i,
   input  logic [N_CH*ADDR_W-1:0]   addr_i,
   input  logic [N_CH-1:0]          prio_i,
   output logic [N_CH-1:0]          gnt_o,
   output logic                     l2_req_o,
   output logic [ADDR_W-1:0]        l2_addr_o,
   input  logic                     l2_gnt_i,
   input  logic                     l2_rvalid_i,
   input  logic [31:0]              l2_rdata_i,
   output logic [N_CH-1:0]          rvalid_o,
   output logic [31:0]              rdata_o,
   output logic                     busy_o,
   output logic                     err_o
);

   localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   typedef enum logic {
      IDLE = 1'b0,
      REQ  = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [IDX_W-1:0]    winner_q, winner_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [IDX_W-1:0]    last_q, last_d;
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [IDX_W-1:0]    fifo_q [DEPTH];

   logic [N_CH-1:0]     pool;
   logic [IDX_W-1:0]    cand;
   logic [IDX_W-1:0]    pick_idx;
   logic                pick_found;
   logic                full;
   logic                push;
   logic                pop;
   logic [N_CH-1:0]     gnt_c;
   logic [N_CH-1:0]     rvalid_c;

   // (base + off) mod N_CH, valid for base < N_CH and off <= N_CH
   function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base,
                                                input int unsigned off);
      int unsigned s;
      s = 32'(base) + off;
      if (s >= N_CH) s = s - N_CH;
      return IDX_W'(s);
   endfunction

   // Candidate pool, then first requester searching upward from last winner + 1
   always_comb begin
      pool = req_i;
`ifdef UDMA_ARB_PRIO_EN
      if (|(req_i & prio_i)) pool = req_i & prio_i;
`endif
      pick_found = 1'b0;
      pick_idx   = '0;
      cand       = '0;
      for (int unsigned i = 1; i <= N_CH; i++) begin
         cand = rr_idx(last_q, i);
         if (!pick_found && pool[cand]) begin
            pick_found = 1'b1;
            pick_idx   = cand;
         end
      end
   end

`ifndef UDMA_ARB_PRIO_EN
   logic unused_prio;
   assign unused_prio = ^prio_i;
`endif

   assign full = (cnt_q == CNT_W'(DEPTH));
   assign pop  = l2_rvalid_i && (cnt_q != '0);

   // Next-state and grant logic
   always_comb begin
      state_d  = state_q;
      winner_d = winner_q;
      addr_d   = addr_q;
      last_d   = last_q;
      push     = 1'b0;
      gnt_c    = '0;
      case (state_q)
         IDLE: begin
            if (pick_found && !full) begin
               winner_d = pick_idx;
               addr_d   = addr_i[32'(pick_idx)*ADDR_W +: ADDR_W];
               state_d  = REQ;
            end
         end
         REQ: begin
            if (l2_gnt_i) begin
               gnt_c[winner_q] = 1'b1;
               push            = 1'b1;
               last_d          = winner_q;
               state_d         = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // ID FIFO pointers, occupancy and sticky error
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      err_d    = err_q;
      rvalid_c = '0;
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop) begin
         rd_ptr_d                   = rd_ptr_q + PTR_W'(1);
         rvalid_c[fifo_q[rd_ptr_q]] = 1'b1;
      end
      case ({push, pop})
         2'b10:   cnt_d = cnt_q + CNT_W'(1);
         2'b01:   cnt_d = cnt_q - CNT_W'(1);
         default: cnt_d = cnt_q;
      endcase
      if (l2_rvalid_i && (cnt_q == '0)) err_d = 1'b1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q  <= IDLE;
         winner_q <= '0;
         addr_q   <= '0;
         last_q   <= IDX_W'(N_CH - 1);
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         addr_q   <= addr_d;
         last_q   <= last_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         err_q    <= err_d;
      end
   end

   // Storage only; validity is tracked by cnt_q
   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= winner_q;
   end

   assign gnt_o     = gnt_c;
   assign rvalid_o  = rvalid_c;
   assign rdata_o   = l2_rdata_i;
   assign l2_req_o  = (state_q == REQ);
   assign l2_addr_o = addr_q;
   assign busy_o    = (state_q == REQ) || (cnt_q != '0);
   assign err_o     = err_q;

endmodule
